// File: rtl/marxkar_jtag.sv
// marxkar_jtag: IEEE 1149.1-style TAP controller for a TinyTapeout tile.
// The JTAG pins arrive on ui_in and are oversampled by clk, so every flop
// runs in the clk domain and TCK edges are detected from synchronised samples.
// Instructions: IDCODE (0001), USER (0010); every other code is BYPASS.
`timescale 1ns/1ps

module marxkar_jtag #(
    parameter logic [31:0] IDCODE_VAL = 32'h4A54_4147,
    parameter int          IR_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // State encodings double as the code shown on uo_out[4:1]
    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

    localparam logic [IR_LEN-1:0] IR_IDCODE  = 4'b0001;
    localparam logic [IR_LEN-1:0] IR_USER    = 4'b0010;
    localparam logic [IR_LEN-1:0] IR_CAPTURE = 4'b0101;

    // Synchroniser stages; tck_prev remembers the last synced TCK level
    logic tck_s1, tck_s2, tck_prev;
    logic tms_s1, tms_s2;
    logic tdi_s1, tdi_s2;
    logic trst_s1, trst_s2;

    logic tck_rise;
    logic tck_fall;

    // TAP state and registers
    tap_state_t        state;
    tap_state_t        next_state;
    logic [IR_LEN-1:0] ir;
    logic [IR_LEN-1:0] ir_shift;
    logic [31:0]       idcode_sr;
    logic              bypass_sr;
    logic [7:0]        user_sr;
    logic [7:0]        user_upd;
    logic              tdo;

    logic sel_idcode;
    logic sel_user;
    logic dr_lsb;

    // The tile enable, bidir inputs and upper ui_in bits carry no function
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:4]};

    // All four pins share the same depth so TMS/TDI stay aligned with TCK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_s1   <= 1'b0;
            tck_s2   <= 1'b0;
            tck_prev <= 1'b0;
            tms_s1   <= 1'b0;
            tms_s2   <= 1'b0;
            tdi_s1   <= 1'b0;
            tdi_s2   <= 1'b0;
            trst_s1  <= 1'b1;
            trst_s2  <= 1'b1;
        end else begin
            tck_s1   <= ui_in[0];
            tck_s2   <= tck_s1;
            tck_prev <= tck_s2;
            tms_s1   <= ui_in[1];
            tms_s2   <= tms_s1;
            tdi_s1   <= ui_in[2];
            tdi_s2   <= tdi_s1;
            trst_s1  <= ui_in[3];
            trst_s2  <= trst_s1;
        end
    end

    assign tck_rise = tck_s2 & ~tck_prev;
    assign tck_fall = ~tck_s2 & tck_prev;

    assign sel_idcode = (ir == IR_IDCODE);
    assign sel_user   = (ir == IR_USER);
    assign dr_lsb     = sel_idcode ? idcode_sr[0] :
                        sel_user   ? user_sr[0]   : bypass_sr;

    // Standard 16-state TAP transition table, evaluated with the synced TMS
    always_comb begin
        next_state = TLR;
        case (state)
            TLR:      next_state = tms_s2 ? TLR      : RTI;
            RTI:      next_state = tms_s2 ? SEL_DR   : RTI;
            SEL_DR:   next_state = tms_s2 ? SEL_IR   : CAP_DR;
            CAP_DR:   next_state = tms_s2 ? EX1_DR   : SH_DR;
            SH_DR:    next_state = tms_s2 ? EX1_DR   : SH_DR;
            EX1_DR:   next_state = tms_s2 ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_state = tms_s2 ? EX2_DR   : PAUSE_DR;
            EX2_DR:   next_state = tms_s2 ? UPD_DR   : SH_DR;
            UPD_DR:   next_state = tms_s2 ? SEL_DR   : RTI;
            SEL_IR:   next_state = tms_s2 ? TLR      : CAP_IR;
            CAP_IR:   next_state = tms_s2 ? EX1_IR   : SH_IR;
            SH_IR:    next_state = tms_s2 ? EX1_IR   : SH_IR;
            EX1_IR:   next_state = tms_s2 ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_state = tms_s2 ? EX2_IR   : PAUSE_IR;
            EX2_IR:   next_state = tms_s2 ? UPD_IR   : SH_IR;
            UPD_IR:   next_state = tms_s2 ? SEL_DR   : RTI;
            default:  next_state = TLR;
        endcase
    end

    // TAP engine: TRST wins, TCK rise moves state and acts on the old state, TCK fall drives TDO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TLR;
            ir        <= IR_IDCODE;
            ir_shift  <= '0;
            idcode_sr <= '0;
            bypass_sr <= 1'b0;
            user_sr   <= 8'h00;
            user_upd  <= 8'h00;
            tdo       <= 1'b0;
        end else if (!trst_s2) begin
            state <= TLR;
            ir    <= IR_IDCODE;
        end else if (tck_rise) begin
            state <= next_state;
            case (state)
                CAP_IR: ir_shift <= IR_CAPTURE;
                SH_IR:  ir_shift <= {tdi_s2, ir_shift[IR_LEN-1:1]};
                UPD_IR: ir       <= ir_shift;
                CAP_DR: begin
                    if (sel_idcode) begin
                        idcode_sr <= IDCODE_VAL;
                    end else if (sel_user) begin
                        user_sr <= user_upd;
                    end else begin
                        bypass_sr <= 1'b0;
                    end
                end
                SH_DR: begin
                    if (sel_idcode) begin
                        idcode_sr <= {tdi_s2, idcode_sr[31:1]};
                    end else if (sel_user) begin
                        user_sr <= {tdi_s2, user_sr[7:1]};
                    end else begin
                        bypass_sr <= tdi_s2;
                    end
                end
                UPD_DR: begin
                    if (sel_user) begin
                        user_upd <= user_sr;
                    end
                end
                default: ;
            endcase
            if (next_state == TLR) begin
                ir <= IR_IDCODE;
            end
        end else if (tck_fall) begin
            case (state)
                SH_IR:   tdo <= ir_shift[0];
                SH_DR:   tdo <= dr_lsb;
                default: tdo <= 1'b0;
            endcase
        end
    end

    assign uo_out  = {ir[2:0], state, tdo};
    assign uio_out = user_upd;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_marxkar_jtag.sv
// tb_marxkar_jtag: self-checking bench for the marxkar_jtag TAP tile.
// Expected TDO bits and state codes are queued as stimulus is planned and
// popped as the DUT produces them.
`timescale 1ns/1ps

module tb_marxkar_jtag;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       tck, tms, tdi, trst_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    logic       exp_q[$];
    logic [3:0] exp_state_q[$];

    localparam logic [31:0] IDCODE = 32'h4A54_4147;

    assign ui_in = {4'b0000, trst_n, tdi, tms, tck};

    marxkar_jtag dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Guard against a stuck run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before the test sequence ended");
        $fatal(1, "[TB] watchdog");
    end

    // One TCK period: set TMS/TDI, sample TDO (set by the previous fall), raise then drop TCK
    task automatic tck_pulse(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms = tms_v;
        tdi = tdi_v;
        repeat (4) @(negedge clk);
        tdo_v = uo_out[0];
        tck = 1'b1;
        repeat (4) @(negedge clk);
        tck = 1'b0;
    endtask

    // Walk to Run-Test/Idle through Test-Logic-Reset
    task automatic go_idle();
        logic d;
        for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #50;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (uo_out[4:1] !== 4'hF) begin
            failures++;
            $display("[TB] FAIL reset_state got=%h exp=F", uo_out[4:1]);
        end
        checks++;
        if (uo_out[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_tdo got=%b exp=0", uo_out[0]);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_uio_out got=%h exp=00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL reset_uio_oe got=%h exp=FF", uio_oe);
        end
        checks++;
        if (uo_out[7:5] !== 3'b001) begin
            failures++;
            $display("[TB] FAIL reset_ir got=%b exp=001", uo_out[7:5]);
        end
    endtask

    task automatic test_tms_walk();
        int         ts[10] = '{0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [3:0] es[10] = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h5, 4'h7, 4'h4, 4'hF, 4'hF};
        logic       d;
        logic [3:0] e;
        for (int i = 0; i < 10; i++) exp_state_q.push_back(es[i]);
        for (int i = 0; i < 10; i++) begin
            tck_pulse(ts[i][0], 1'b0, d);
            e = exp_state_q.pop_front();
            checks++;
            if (uo_out[4:1] !== e) begin
                failures++;
                $display("[TB] FAIL walk_state[%0d] got=%h exp=%h", i, uo_out[4:1], e);
            end
        end
    endtask

    task automatic test_idcode();
        logic d, got, e;
        go_idle();
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE[i]);
        for (int i = 0; i < 32; i++) begin
            tck_pulse(i == 31, 1'b0, got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL idcode_bit[%0d] got=%b exp=%b", i, got, e);
            end
        end
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        checks++;
        if (uo_out[4:1] !== 4'hC) begin
            failures++;
            $display("[TB] FAIL idcode_exit_state got=%h exp=C", uo_out[4:1]);
        end
    endtask

    task automatic test_ir_bypass();
        logic d, got, e, prev;
        int   pat[5] = '{1, 0, 1, 1, 0};
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        checks++;
        if (uo_out[4:1] !== 4'hA) begin
            failures++;
            $display("[TB] FAIL shir_state got=%h exp=A", uo_out[4:1]);
        end
        // Captured 0101 emerges LSB first as 1,0,1,0
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            tck_pulse(i == 3, 1'b1, got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL ir_capture_bit[%0d] got=%b exp=%b", i, got, e);
            end
        end
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        checks++;
        if (uo_out[7:5] !== 3'b111) begin
            failures++;
            $display("[TB] FAIL bypass_ir got=%b exp=111", uo_out[7:5]);
        end
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        // BYPASS: TDO is TDI delayed by one TCK, starting from the captured 0
        prev = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(prev);
            prev = pat[i][0];
        end
        for (int i = 0; i < 5; i++) begin
            tck_pulse(i == 4, pat[i][0], got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL bypass_bit[%0d] got=%b exp=%b", i, got, e);
            end
        end
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
    endtask

    task automatic test_user();
        logic       d, got, e;
        logic [3:0] ir_user = 4'b0010;
        logic [7:0] wr_val  = 8'hA5;
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            tck_pulse(i == 3, ir_user[i], got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL user_ir_capture_bit[%0d] got=%b exp=%b", i, got, e);
            end
        end
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        checks++;
        if (uo_out[7:5] !== 3'b010) begin
            failures++;
            $display("[TB] FAIL user_ir got=%b exp=010", uo_out[7:5]);
        end
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        // USER captures its update register, still 00 here
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            tck_pulse(i == 7, wr_val[i], got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL user_capture_bit[%0d] got=%b exp=%b", i, got, e);
            end
        end
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        checks++;
        if (uio_out !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL user_update got=%h exp=A5", uio_out);
        end
    endtask

    task automatic test_back_to_back();
        logic       d, got, e;
        logic [7:0] old_val = 8'hA5;
        logic [7:0] new_val = 8'h3C;
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        for (int i = 0; i < 8; i++) exp_q.push_back(old_val[i]);
        for (int i = 0; i < 8; i++) begin
            tck_pulse(i == 7, new_val[i], got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL user_readback_bit[%0d] got=%b exp=%b", i, got, e);
            end
        end
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        checks++;
        if (uio_out !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL user_second_update got=%h exp=3C", uio_out);
        end
    endtask

    task automatic test_trst();
        logic d;
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        tck_pulse(1'b0, 1'b1, d);
        tck_pulse(1'b0, 1'b1, d);
        checks++;
        if (uo_out[4:1] !== 4'h2) begin
            failures++;
            $display("[TB] FAIL trst_pre_state got=%h exp=2", uo_out[4:1]);
        end
        trst_n = 1'b0;
        repeat (3) @(negedge clk);
        trst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (uo_out[4:1] !== 4'hF) begin
            failures++;
            $display("[TB] FAIL trst_state got=%h exp=F", uo_out[4:1]);
        end
        checks++;
        if (uo_out[7:5] !== 3'b001) begin
            failures++;
            $display("[TB] FAIL trst_ir got=%b exp=001", uo_out[7:5]);
        end
        checks++;
        if (uio_out !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL trst_uio_out got=%h exp=3C", uio_out);
        end
    endtask

    task automatic test_pause_idcode();
        logic       d, got, e;
        logic [3:0] es;
        int         pt[4] = '{0, 0, 1, 0};
        logic [3:0] ps[4] = '{4'h3, 4'h3, 4'h0, 4'h2};
        tck_pulse(1'b0, 1'b0, d);
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        for (int i = 0; i < 16; i++) exp_q.push_back(IDCODE[i]);
        for (int i = 0; i < 4; i++)  exp_q.push_back(1'b0);
        for (int i = 16; i < 32; i++) exp_q.push_back(IDCODE[i]);
        for (int i = 0; i < 4; i++)  exp_state_q.push_back(ps[i]);
        for (int i = 0; i < 16; i++) begin
            tck_pulse(i == 15, 1'($urandom_range(1, 0)), got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL pause_id_bit[%0d] got=%b exp=%b", i, got, e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tck_pulse(pt[i][0], 1'b1, got);
            e  = exp_q.pop_front();
            es = exp_state_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL pause_tdo[%0d] got=%b exp=%b", i, got, e);
            end
            checks++;
            if (uo_out[4:1] !== es) begin
                failures++;
                $display("[TB] FAIL pause_state[%0d] got=%h exp=%h", i, uo_out[4:1], es);
            end
        end
        for (int i = 16; i < 32; i++) begin
            tck_pulse(i == 31, 1'($urandom_range(1, 0)), got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL pause_id_bit[%0d] got=%b exp=%b", i, got, e);
            end
        end
        tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
    endtask

    // Scenario sequence
    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        tck    = 1'b0;
        tms    = 1'b0;
        tdi    = 1'b0;
        trst_n = 1'b1;
        test_reset();
        test_tms_walk();
        test_idcode();
        test_ir_bypass();
        test_user();
        test_back_to_back();
        test_trst();
        test_pause_idcode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
